// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// dmem_port_arbiter: shares the single data-memory port between the LSU and a debug/loader port.
// LSU has priority, a starvation counter guarantees DBG progress, and a lock handshake hands DBG exclusive ownership.
module dmem_port_arbiter #(
  parameter int AW           = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,

  input  logic          i_lsu_req,
  input  logic          i_lsu_we,
  input  logic [AW-1:0] i_lsu_addr,
  input  logic [31:0]   i_lsu_wdata,
  input  logic [3:0]    i_lsu_be,
  output logic          o_lsu_gnt,
  output logic          o_lsu_rvalid,
  output logic [31:0]   o_lsu_rdata,

  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [31:0]   i_dbg_wdata,
  input  logic [3:0]    i_dbg_be,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [31:0]   o_dbg_rdata,

  input  logic          i_dbg_lock,
  output logic          o_lock_ack,

  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_be,
  input  logic [31:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  state_t     state;
  owner_t     rsp_owner;
  logic [3:0] starve_cnt;

  logic       starved;
  logic       lsu_win;
  logic       dbg_win;
  logic       lsu_read;
  logic       dbg_read;
  logic       lsu_rvalid;
  logic       dbg_rvalid;

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  // Grants are gated by reset so nothing reaches memory while reset is asserted.
  always_comb begin
    lsu_win = 1'b0;
    dbg_win = 1'b0;
    if (i_rst_n) begin
      if (state == ST_NORMAL) begin
        if (i_lsu_req && !(i_dbg_req && starved)) begin
          lsu_win = 1'b1;
        end else if (i_dbg_req) begin
          dbg_win = 1'b1;
        end
      end else begin
        dbg_win = i_dbg_req;
      end
    end
  end

  assign lsu_read = lsu_win && !i_lsu_we;
  assign dbg_read = dbg_win && !i_dbg_we;

  assign o_lsu_gnt = lsu_win;
  assign o_dbg_gnt = dbg_win;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    if (lsu_win) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_lsu_we;
      o_mem_addr  = i_lsu_addr;
      o_mem_wdata = i_lsu_wdata;
      o_mem_be    = i_lsu_be;
    end else if (dbg_win) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_dbg_we;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_wdata;
      o_mem_be    = i_dbg_be;
    end
  end

  // A response still in flight when reset arrives is dropped, not delivered.
  assign lsu_rvalid   = i_rst_n && (rsp_owner == OWN_LSU);
  assign dbg_rvalid   = i_rst_n && (rsp_owner == OWN_DBG);
  assign o_lsu_rvalid = lsu_rvalid;
  assign o_dbg_rvalid = dbg_rvalid;
  assign o_lsu_rdata  = lsu_rvalid ? i_mem_rdata : 32'd0;
  assign o_dbg_rdata  = dbg_rvalid ? i_mem_rdata : 32'd0;
  assign o_lock_ack   = i_rst_n && (state == ST_LOCKED);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_NORMAL;
      rsp_owner  <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      if (lsu_read) begin
        rsp_owner <= OWN_LSU;
      end else if (dbg_read) begin
        rsp_owner <= OWN_DBG;
      end else begin
        rsp_owner <= OWN_NONE;
      end

      if ((state == ST_LOCKED) || !i_dbg_req || dbg_win) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      // DRAIN holds until no read is left owing a response past this edge.
      case (state)
        ST_NORMAL: if (i_dbg_lock) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!i_dbg_lock) begin
            state <= ST_NORMAL;
          end else if (!(lsu_read || dbg_read)) begin
            state <= ST_LOCKED;
          end
        end
        ST_LOCKED: if (!i_dbg_lock) state <= ST_NORMAL;
        default: state <= ST_NORMAL;
      endcase
    end
  end

endmodule
`default_nettype wire
